// File: rtl/srio_hit_pkg.sv
// Shared constants and types for the hit frame assembler: header layout,
// descriptor format and output FSM state encoding.
package srio_hit_pkg;

    localparam logic [7:0] HDR_MAGIC = 8'hA5;

    localparam int HDR_MAGIC_LSB = 56;
    localparam int HDR_SEQ_LSB   = 48;
    localparam int HDR_OFFS_LSB  = 32;
    localparam int HDR_FCNT_LSB  = 16;
    localparam int HDR_CNT_LSB   = 0;

    localparam int SEQ_F_W  = 3;
    localparam int OFFS_F_W = 10;
    localparam int CNT_F_W  = 16;

    typedef struct packed {
        logic [SEQ_F_W-1:0]  seq;
        logic [OFFS_F_W-1:0] offset;
        logic [CNT_F_W-1:0]  beat_cnt;
    } desc_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_TRL  = 2'd3;

    function automatic logic [63:0] make_header(desc_t d, logic [15:0] fcnt);
        logic [63:0] h;
        h = '0;
        h[HDR_MAGIC_LSB +: 8]       = HDR_MAGIC;
        h[HDR_SEQ_LSB   +: SEQ_F_W]  = d.seq;
        h[HDR_OFFS_LSB  +: OFFS_F_W] = d.offset;
        h[HDR_FCNT_LSB  +: 16]       = fcnt;
        h[HDR_CNT_LSB   +: CNT_F_W]  = d.beat_cnt;
        return h;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy-derived full,
// empty and free-entry count. DEPTH must be a power of 2.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] free
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             wr_ok;
    logic             rd_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign free    = CW'(DEPTH) - count;
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(wr_ok) - CW'(rd_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/hit_frame_assembler.sv
// Store-and-forward framer: buffers each read burst, then emits header + data
// on AXI4-Stream. Define HIT_FRAME_CHKSUM_EN to append an XOR trailer beat.
module hit_frame_assembler
    import srio_hit_pkg::*;
#(
    parameter int DATA_WIDTH      = 64,
    parameter int DATA_FIFO_DEPTH = 128,
    parameter int DESC_FIFO_DEPTH = 4,
    parameter int MAX_BEATS       = 32,
    parameter int SEQ_WIDTH       = 3,
    parameter int OFFS_WIDTH      = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rd_data_valid_in,
    input  logic [DATA_WIDTH-1:0] rd_data_in,
    input  logic [SEQ_WIDTH-1:0]  hit_pack_seq_in,
    input  logic [OFFS_WIDTH-1:0] hit_addr_offset_in,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic [15:0]           frame_cnt_out,
    output logic [15:0]           drop_cnt_out,
    output logic                  overflow_out
);

    localparam int BW  = $clog2(MAX_BEATS + 1);
    localparam int DAW = $clog2(DATA_FIFO_DEPTH) + 1;
    localparam int DDW = $clog2(DESC_FIFO_DEPTH) + 1;

    // ---------------- input side: burst tracking and admission
    logic                  active;
    logic                  admit;
    logic [BW-1:0]         beat_cnt;
    logic [SEQ_WIDTH-1:0]  cur_seq;
    logic [OFFS_WIDTH-1:0] cur_offs;

    logic                  at_max, burst_start, burst_end, desc_push, admit_ok, data_wr;
    logic [SEQ_WIDTH-1:0]  new_seq;
    logic [OFFS_WIDTH-1:0] new_offs;

    logic [DATA_WIDTH-1:0] data_head;
    logic                  data_full, data_empty, data_pop;
    logic [DAW-1:0]        data_free;
    desc_t                 desc_in, desc_out;
    logic                  desc_full, desc_empty, desc_pop;
    logic [DDW-1:0]        desc_free;

    assign at_max      = active && (beat_cnt == BW'(MAX_BEATS));
    assign burst_start = rd_data_valid_in && (!active || at_max);
    assign burst_end   = active && (!rd_data_valid_in || at_max);
    assign desc_push   = burst_end && admit;
    // A beat continuing past MAX_BEATS keeps the seq and advances the offset.
    assign new_seq     = at_max ? cur_seq : hit_pack_seq_in;
    assign new_offs    = at_max ? cur_offs + OFFS_WIDTH'(MAX_BEATS << 3) : hit_addr_offset_in;
    // Descriptor room must survive a push of the previous burst in this same cycle.
    assign admit_ok    = (data_free >= DAW'(MAX_BEATS)) && (desc_free > DDW'(desc_push));
    assign data_wr     = rd_data_valid_in && (burst_start ? admit_ok : admit) && !data_full;

    assign desc_in.seq      = SEQ_F_W'(cur_seq);
    assign desc_in.offset   = OFFS_F_W'(cur_offs);
    assign desc_in.beat_cnt = CNT_F_W'(beat_cnt);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active       <= 1'b0;
            admit        <= 1'b0;
            beat_cnt     <= '0;
            cur_seq      <= '0;
            cur_offs     <= '0;
            drop_cnt_out <= '0;
            overflow_out <= 1'b0;
        end else if (burst_start) begin
            active   <= 1'b1;
            admit    <= admit_ok;
            beat_cnt <= BW'(1);
            cur_seq  <= new_seq;
            cur_offs <= new_offs;
            if (!admit_ok) begin
                overflow_out <= 1'b1;
                if (drop_cnt_out != 16'hFFFF) drop_cnt_out <= drop_cnt_out + 16'd1;
            end
        end else if (rd_data_valid_in) begin
            beat_cnt <= beat_cnt + BW'(1);
        end else if (active) begin
            active <= 1'b0;
        end
    end

    sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(DATA_FIFO_DEPTH)) u_data_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (data_wr),
        .wr_data (rd_data_in),
        .rd_en   (data_pop),
        .rd_data (data_head),
        .full    (data_full),
        .empty   (data_empty),
        .free    (data_free)
    );

    sync_fifo #(.WIDTH($bits(desc_t)), .DEPTH(DESC_FIFO_DEPTH)) u_desc_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (desc_push && !desc_full),
        .wr_data (desc_in),
        .rd_en   (desc_pop),
        .rd_data (desc_out),
        .full    (desc_full),
        .empty   (desc_empty),
        .free    (desc_free)
    );

    // ---------------- output side: IDLE -> HDR -> DATA (-> TRL) -> IDLE
    logic [1:0]  state;
    desc_t       cur_desc;
    logic [15:0] out_cnt;
    logic        last_data, hs;
`ifdef HIT_FRAME_CHKSUM_EN
    logic [DATA_WIDTH-1:0] xor_acc;
`endif

    assign desc_pop  = (state == ST_IDLE) && !desc_empty;
    assign last_data = (out_cnt == cur_desc.beat_cnt);
    assign hs        = m_axis_tvalid && m_axis_tready;
    assign data_pop  = (state == ST_DATA) && hs;

    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tlast  = 1'b0;
        case (state)
            ST_HDR: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = DATA_WIDTH'(make_header(cur_desc, frame_cnt_out));
            end
            ST_DATA: begin
                m_axis_tvalid = !data_empty;
                m_axis_tdata  = data_head;
`ifndef HIT_FRAME_CHKSUM_EN
                m_axis_tlast  = last_data;
`endif
            end
`ifdef HIT_FRAME_CHKSUM_EN
            ST_TRL: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = xor_acc;
                m_axis_tlast  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            cur_desc      <= '0;
            out_cnt       <= '0;
            frame_cnt_out <= '0;
`ifdef HIT_FRAME_CHKSUM_EN
            xor_acc       <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!desc_empty) begin
                        cur_desc <= desc_out;
                        state    <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (hs) begin
                        state   <= ST_DATA;
                        out_cnt <= 16'd1;
`ifdef HIT_FRAME_CHKSUM_EN
                        xor_acc <= '0;
`endif
                    end
                end
                ST_DATA: begin
                    if (hs) begin
                        out_cnt <= out_cnt + 16'd1;
`ifdef HIT_FRAME_CHKSUM_EN
                        xor_acc <= xor_acc ^ data_head;
                        if (last_data) state <= ST_TRL;
`else
                        if (last_data) begin
                            state         <= ST_IDLE;
                            frame_cnt_out <= frame_cnt_out + 16'd1;
                        end
`endif
                    end
                end
`ifdef HIT_FRAME_CHKSUM_EN
                ST_TRL: begin
                    if (hs) begin
                        state         <= ST_IDLE;
                        frame_cnt_out <= frame_cnt_out + 16'd1;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/hit_frame_assembler.md
Name: hit_frame_assembler

Overview:
- Sits downstream of ram_controller and consumes its hash-hit readout stream (rd_data_valid/rd_data).
- Groups each contiguous run of read beats into one frame and prefixes it with a header beat carrying packet sequence, address offset and beat count.
- Emits frames as AXI4-Stream toward the SRIO transmit path.
- Store-and-forward: the read stream has no backpressure, so a frame is only released once fully buffered.

Parameters:
- DATA_WIDTH, 64: beat width.
- DATA_FIFO_DEPTH, 128: data FIFO entries; power of 2, at least 2*MAX_BEATS.
- DESC_FIFO_DEPTH, 4: descriptor FIFO entries; power of 2.
- MAX_BEATS, 32: maximum data beats per frame.
- SEQ_WIDTH, 3: packet sequence width (8 RAM banks).
- OFFS_WIDTH, 10: RAM address offset width.

Ports:
- clk, input, 1: single clock.
- reset_n, input, 1: asynchronous, active-low reset.
- rd_data_valid_in, input, 1: read beat valid from ram_controller.
- rd_data_in, input, DATA_WIDTH: read beat.
- hit_pack_seq_in, input, SEQ_WIDTH: sequence of the packet being read; sampled on the first beat.
- hit_addr_offset_in, input, OFFS_WIDTH: offset of the first beat; sampled on the first beat.
- m_axis_tvalid, output, 1: output beat valid.
- m_axis_tready, input, 1: downstream ready.
- m_axis_tdata, output, DATA_WIDTH: output beat.
- m_axis_tlast, output, 1: last beat of frame.
- frame_cnt_out, output, 16: frames fully sent; wraps.
- drop_cnt_out, output, 16: bursts dropped; saturates at 0xFFFF.
- overflow_out, output, 1: sticky drop flag; cleared only by reset.

Behaviour:
- Reset (async, reset_n low): all outputs 0, FIFOs empty, FSM in IDLE, counters 0.
- Burst start: rd_data_valid_in high while the previous cycle was low, or the previous beat completed a MAX_BEATS frame.
  - Capture seq and offset.
  - Admission check: data FIFO free entries >= MAX_BEATS and descriptor FIFO not full.
- Admitted burst: every beat is written to the data FIFO and beat_cnt increments.
- Failed admission: the whole burst is discarded, drop_cnt_out increments once, overflow_out is set. No partial frame is ever emitted.
- Burst end: the first cycle with valid low after a beat, or beat_cnt reaching MAX_BEATS.
  - At this edge push descriptor {seq, offset, beat_cnt} to the descriptor FIFO.
  - On a MAX_BEATS split, a continuing beat starts a new burst with offset = previous offset + (MAX_BEATS<<3), modulo 2^OFFS_WIDTH, and the same seq.
- Header beat layout:
  - [63:56] = 8'hA5
  - [50:48] = seq
  - [41:32] = offset
  - [31:16] = frame_cnt_out
  - [15:0] = beat_cnt
  - all other bits 0
- Output FSM: IDLE -> HDR -> DATA -> IDLE.
  - IDLE: when the descriptor FIFO is non-empty, pop it and go to HDR. tvalid is high the next cycle.
  - HDR: drive the header; on tvalid&&tready go to DATA.
  - DATA: drive data FIFO head beats; each handshake pops one. tlast is asserted on beat number beat_cnt.
  - On the last handshake, increment frame_cnt_out and go to IDLE.
- Latency: last beat of a burst in cycle N; header on m_axis in cycle N+3, given the FSM is idle.
- AXI rules:
  - tdata/tlast are stable while tvalid && !tready.
  - No bubbles inside a frame, since the data is already buffered.
  - Back-to-back frames have one IDLE cycle between them.
- Simultaneous events: a data FIFO write and read in the same cycle are both honoured. A descriptor push and pop in the same cycle are both honoured.
- Reset mid-frame: the frame is abandoned and tvalid drops asynchronously.

Optional Feature:
- Macro: HIT_FRAME_CHKSUM_EN.
- Defined: after the last data beat a trailer beat carries the 64-bit XOR of all data beats of the frame. tlast moves to the trailer, and the FSM gains a TRL state (DATA -> TRL -> IDLE).
- Undefined: no trailer; tlast is on the last data beat.

Decomposition:
- Package srio_hit_pkg:
  - HDR_MAGIC = 8'hA5
  - header field bit positions
  - descriptor struct typedef {seq, offset, beat_cnt}
  - FSM state enum (IDLE, HDR, DATA, TRL)
- Sub-module: sync_fifo (parameterised width/depth, reset_n, full/empty/free count), instantiated twice, once for data and once for descriptors.

Test Plan:
- Single burst of 8 beats 0x1..0x8, seq=3, offset=0x018, tready=1 -> header 0xA503_0018_0000_0008 3 cycles after the last beat, then 8 data beats, tlast on 0x8, frame_cnt_out=1.
- Burst of 40 beats, offset=0 -> two frames: 32 beats at offset 0x000, then 8 beats at offset 0x100, same seq.
- tready toggled 1/0 every cycle during a 16-beat frame -> data unchanged while stalled, all 16 beats in order, tlast once.
- tready=0 while 5 bursts of 32 beats arrive (DATA_FIFO_DEPTH=128) -> 4 admitted, 5th dropped, drop_cnt_out=1, overflow_out=1; releasing tready yields 4 complete frames.
- reset_n pulsed low mid-DATA -> tvalid=0 immediately, counters 0; a new 4-beat burst afterwards frames correctly.
- With HIT_FRAME_CHKSUM_EN, beats 0xF0, 0x0F, 0xFF -> trailer 0x00 carrying tlast.
